// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: chooses advance / hold / redirect for the PC, drives the
// IF/ID write and flush controls, and keeps a redirect target across memory wait cycles.
module pc_sequencer #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_req,
    input  logic                 branch_taken_ID,
    input  logic                 jump_ID,
    input  logic                 halt_ID,
    input  logic [WIDTH-1:0]     id_target,
    input  logic                 imem_ready,
    output logic                 PCSource,
    output logic [WIDTH-1:0]     target_pc,
    output logic                 PCWrite,
    output logic                 IFID_Write,
    output logic                 IFID_Flush,
    output logic [CNT_WIDTH-1:0] redirect_count,
    output logic [1:0]           ctrl_state
);

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        REDIR_WAIT = 2'd1,
        HALTED     = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     target_q, target_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 redirect;

    assign redirect = branch_taken_ID | jump_ID;

    // Mealy control: outputs default to "bubble into IF/ID, hold PC", which is also the reset view.
    always_comb begin
        PCSource   = 1'b0;
        target_pc  = target_q;
        PCWrite    = 1'b0;
        IFID_Write = 1'b1;
        IFID_Flush = 1'b1;
        state_d    = state_q;
        target_d   = target_q;

        if (rst) begin
            target_pc = '0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (halt_ID && !stall_req) begin
                        state_d = HALTED;
                    end else if (stall_req) begin
                        IFID_Write = 1'b0;
                        IFID_Flush = 1'b0;
                    end else if (redirect) begin
                        PCSource  = 1'b1;
                        target_pc = id_target;
                        PCWrite   = imem_ready;
                        if (!imem_ready) begin
                            target_d = id_target;
                            state_d  = REDIR_WAIT;
                        end
                    end else begin
                        PCWrite    = imem_ready;
                        IFID_Flush = !imem_ready;
                    end
                end
                // ID holds a bubble here, so its stall/redirect/halt requests are stale.
                REDIR_WAIT: begin
                    PCSource = 1'b1;
                    PCWrite  = imem_ready;
                    if (imem_ready) begin
                        state_d = FETCH;
                    end
                end
                HALTED: begin
                    IFID_Write = 1'b0;
                    IFID_Flush = 1'b0;
                end
                default: begin
                    IFID_Write = 1'b0;
                    IFID_Flush = 1'b0;
                    state_d    = FETCH;
                end
            endcase
        end
    end

    // A redirect is counted when the PC actually loads from the target side.
    always_comb begin
        count_d = count_q;
        if (PCWrite && PCSource && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            target_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
        end
    end

    assign redirect_count = count_q;
    assign ctrl_state     = rst ? 2'd0 : state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the main flow, then hand sequences
// for reset-out-of-halt, reset mid-wait and counter saturation (checked on a narrow-counter copy).
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall_req;
    logic        branch_taken_ID;
    logic        jump_ID;
    logic        halt_ID;
    logic [31:0] id_target;
    logic        imem_ready;

    logic        PCSource, PCWrite, IFID_Write, IFID_Flush;
    logic [31:0] target_pc;
    logic [15:0] redirect_count;
    logic [1:0]  ctrl_state;

    logic        sPCSource, sPCWrite, sIFID_Write, sIFID_Flush;
    logic [31:0] sTarget_pc;
    logic [3:0]  sRedirect_count;
    logic [1:0]  sCtrl_state;

    int total = 0;
    int bad   = 0;

    pc_sequencer #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken_ID(branch_taken_ID),
        .jump_ID(jump_ID), .halt_ID(halt_ID), .id_target(id_target), .imem_ready(imem_ready),
        .PCSource(PCSource), .target_pc(target_pc), .PCWrite(PCWrite),
        .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .redirect_count(redirect_count), .ctrl_state(ctrl_state)
    );

    pc_sequencer #(.WIDTH(32), .CNT_WIDTH(4)) dutSmall (
        .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken_ID(branch_taken_ID),
        .jump_ID(jump_ID), .halt_ID(halt_ID), .id_target(id_target), .imem_ready(imem_ready),
        .PCSource(sPCSource), .target_pc(sTarget_pc), .PCWrite(sPCWrite),
        .IFID_Write(sIFID_Write), .IFID_Flush(sIFID_Flush),
        .redirect_count(sRedirect_count), .ctrl_state(sCtrl_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic        jmp;
        logic        halt;
        logic [31:0] tgt;
        logic        ready;
        logic        expPCSource;
        logic [31:0] expTarget;
        logic        expPCWrite;
        logic        expIFIDWrite;
        logic        expFlush;
        logic [1:0]  expState;
        logic [15:0] expCountAfter;
    } vec_t;

    vec_t vecs[16];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h want=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic br, input logic jmp,
                                 input logic halt, input logic [31:0] tgt, input logic ready);
        @(negedge clk);
        stall_req       = stall;
        branch_taken_ID = br;
        jump_ID         = jmp;
        halt_ID         = halt;
        id_target       = tgt;
        imem_ready      = ready;
        #1;
    endtask

    task automatic checkAll(input string tag, input logic pcs, input logic [31:0] tgt, input logic pcw,
                            input logic iw, input logic fl, input logic [1:0] st);
        checkOutput({tag, ".PCSource"},   32'(PCSource),   32'(pcs));
        checkOutput({tag, ".target_pc"},  target_pc,       tgt);
        checkOutput({tag, ".PCWrite"},    32'(PCWrite),    32'(pcw));
        checkOutput({tag, ".IFID_Write"}, 32'(IFID_Write), 32'(iw));
        checkOutput({tag, ".IFID_Flush"}, 32'(IFID_Flush), 32'(fl));
        checkOutput({tag, ".ctrl_state"}, 32'(ctrl_state), 32'(st));
    endtask

    initial begin
        // stall br jmp halt target ready | PCS target PCW IW FL state countAfter
        vecs[0]  = '{0,0,0,0,32'h0,  1, 0,32'h0,  1,1,0, 2'd0, 16'd0};
        vecs[1]  = '{0,0,0,0,32'h0,  1, 0,32'h0,  1,1,0, 2'd0, 16'd0};
        vecs[2]  = '{0,0,0,0,32'h0,  1, 0,32'h0,  1,1,0, 2'd0, 16'd0};
        vecs[3]  = '{0,1,0,0,32'h40, 1, 1,32'h40, 1,1,1, 2'd0, 16'd1};
        vecs[4]  = '{0,0,0,0,32'h0,  0, 0,32'h0,  0,1,1, 2'd0, 16'd1};
        vecs[5]  = '{0,0,1,0,32'h100,0, 1,32'h100,0,1,1, 2'd0, 16'd1};
        vecs[6]  = '{0,0,0,0,32'h200,0, 1,32'h100,0,1,1, 2'd1, 16'd1};
        vecs[7]  = '{1,0,1,1,32'h200,0, 1,32'h100,0,1,1, 2'd1, 16'd1};
        vecs[8]  = '{0,0,0,0,32'h200,1, 1,32'h100,1,1,1, 2'd1, 16'd2};
        vecs[9]  = '{1,1,0,0,32'h80, 1, 0,32'h100,0,0,0, 2'd0, 16'd2};
        vecs[10] = '{0,1,0,0,32'h80, 1, 1,32'h80, 1,1,1, 2'd0, 16'd3};
        vecs[11] = '{1,0,0,0,32'h0,  0, 0,32'h100,0,0,0, 2'd0, 16'd3};
        vecs[12] = '{1,0,0,1,32'h0,  1, 0,32'h100,0,0,0, 2'd0, 16'd3};
        vecs[13] = '{0,0,1,1,32'h300,1, 0,32'h100,0,1,1, 2'd0, 16'd3};
        vecs[14] = '{0,0,0,0,32'h0,  1, 0,32'h100,0,0,0, 2'd2, 16'd3};
        vecs[15] = '{0,1,0,0,32'h500,1, 0,32'h100,0,0,0, 2'd2, 16'd3};

        rst = 1'b1;
        stall_req = 0; branch_taken_ID = 0; jump_ID = 0; halt_ID = 0;
        id_target = 32'hDEAD_BEEF; imem_ready = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkAll("reset", 0, 32'h0, 0, 1, 1, 2'd0);
        checkOutput("reset.count", 32'(redirect_count), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].br, vecs[i].jmp, vecs[i].halt, vecs[i].tgt, vecs[i].ready);
            checkAll($sformatf("vec%0d", i), vecs[i].expPCSource, vecs[i].expTarget,
                     vecs[i].expPCWrite, vecs[i].expIFIDWrite, vecs[i].expFlush, vecs[i].expState);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d.count", i), 32'(redirect_count), 32'(vecs[i].expCountAfter));
        end

        // Reset leaves HALTED and clears the counter.
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("haltExit.state", 32'(ctrl_state), 32'd0);
        checkOutput("haltExit.count", 32'(redirect_count), 32'd0);

        // Reset in the middle of a pending redirect drops it.
        applyStimulus(0, 0, 1, 0, 32'h700, 0);
        @(posedge clk);
        #1;
        checkOutput("midWait.enter", 32'(ctrl_state), 32'd1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        rst = 1'b1;
        #1;
        checkAll("midWait.rst", 0, 32'h0, 0, 1, 1, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        checkAll("midWait.after", 0, 32'h0, 1, 1, 0, 2'd0);
        @(posedge clk);
        #1;
        checkOutput("midWait.count", 32'(redirect_count), 32'd0);

        // Seventeen immediate redirects: the 4-bit counter pins at all-ones, the 16-bit one keeps going.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(0, (i % 2) == 0, (i % 2) == 1, 0, 32'(i * 4), 1);
            @(posedge clk);
            #1;
            if (i == 14) checkOutput("sat.small15", 32'(sRedirect_count), 32'hF);
        end
        checkOutput("sat.smallHold", 32'(sRedirect_count), 32'hF);
        checkOutput("sat.big",       32'(redirect_count),  32'd17);

        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
